// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Purpose  : Shared AHB-Lite encodings and the memory-port FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_ERR1 = 3'd4,
    ST_ERR2 = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_lane_decode.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lane_decode
// Purpose  : Byte-lane mask and illegal-size detection for one AHB transfer.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_lane_decode
  import ahb_pkg::*;
#(
  parameter int BE_W = 2
) (
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       size_err
);

  always_comb begin
    mask     = 4'b0000;
    size_err = 1'b0;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        mask     = 4'b0011 << {addr_lo[1], 1'b0};
        size_err = addr_lo[0];
      end
      HSIZE_WORD: begin
        mask     = 4'b1111;
        size_err = |addr_lo;
      end
      default: size_err = 1'b1;
    endcase
    // Lanes beyond the RAM word width have nowhere to land.
    if (|(mask >> BE_W)) size_err = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/ahb_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mem_port
// Purpose  : AHB-Lite slave driving a single-port synchronous block RAM.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_mem_port
  import ahb_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int READBACK = 1,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              HRESETN,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] mask;
  logic       size_err;
  logic       accept;
  logic       unused_bits;

  ahb_lane_decode #(.BE_W(BE_W)) u_lane_decode (
    .size     (HSIZE),
    .addr_lo  (HADDR[1:0]),
    .mask     (mask),
    .size_err (size_err)
  );

  // Wait states never see an accept; the guard keeps mem_addr stable anyway.
  assign accept = HSEL & HTRANS[1] & HREADY & (state != ST_RD1) & (state != ST_ERR1);

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_RD1:  state_nxt = ST_RD2;
      ST_ERR1: state_nxt = ST_ERR2;
      default: begin
        if (accept) begin
          if (size_err)           state_nxt = ST_ERR1;
          else if (HWRITE)        state_nxt = ST_WR;
          else if (READBACK != 0) state_nxt = ST_RD1;
          else                    state_nxt = ST_RD2;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!HRESETN) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      mem_be   <= '0;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
    end else begin
      state  <= state_nxt;
      mem_we <= (state_nxt == ST_WR);
      mem_re <= (state_nxt == ST_RD1);
      mem_be <= (state_nxt == ST_WR) ? mask[BE_W-1:0] : '0;
      if (accept) mem_addr <= HADDR[ADDR_W+1:2];
    end
  end

  assign HREADYOUT = !((state == ST_RD1) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign mem_wdata = HWDATA[DATA_W-1:0];

  always_comb begin
    HRDATA = '0;
    if ((state == ST_RD2) && (READBACK != 0)) HRDATA[DATA_W-1:0] = mem_rdata;
  end

  assign unused_bits = ^{HADDR[31:ADDR_W+2], HTRANS[0], HWDATA, mask};

endmodule
`default_nettype wire
